// File: rtl/top_pkg.sv
// Shared width constants for the registered ripple-carry adder slice.
package top_pkg;

    localparam int ADD_WIDTH = 4;
    localparam int SUM_WIDTH = ADD_WIDTH + 1;

endpackage

// File: rtl/top_full_adder.sv
// One-bit combinational full adder; the building block of the ripple chain in top.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/top.sv
// Registered adder: {cout,S} <= a + b + ci through a ripple chain of full adders.
// The result register is the only state, so results trail operands by one edge.
module top
    import top_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;

    assign carry[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        sum_d = {carry[WIDTH], sum_bits};
    end

    // Reset wins over whatever operands are presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign S    = sum_q[WIDTH-1:0];
    assign cout = sum_q[WIDTH];

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed cases, a random back-to-back stream with
// a mid-stream reset, and an exhaustive operand sweep against plain integer addition.
module tb_top;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] S;
    logic       cout;

    int n_checks;
    int n_fail;

    logic [4:0] exp_q[$];
    logic [4:0] prev_exp;
    logic       have_prev;

    top #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .S    (S),
        .cout (cout)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the registered result is the full-precision sum, or zero under reset.
    function automatic logic [4:0] model(input logic r, input logic [3:0] av,
                                         input logic [3:0] bv, input logic cv);
        int total;
        total = int'(av) + int'(bv) + int'(cv);
        if (r) return 5'd0;
        return total[4:0];
    endfunction

    // Drive one operand set at negedge, check the register still holds the old
    // value, then check the new result just after the following rising edge.
    task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv,
                        input logic cv, input string tag);
        logic [4:0] e;
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        ci  = cv;
        exp_q.push_back(model(r, av, bv, cv));
        #1;
        if (have_prev) check({tag, "_hold"}, {27'd0, cout, S}, {27'd0, prev_exp});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_S"}, {28'd0, S}, {28'd0, e[3:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, e[4]});
        prev_exp  = e;
        have_prev = 1'b1;
    endtask

    initial begin
        int rst_at;
        n_checks  = 0;
        n_fail    = 0;
        have_prev = 1'b0;
        prev_exp  = '0;
        rst = 1'b1;
        a   = 4'd5;
        b   = 4'd5;
        ci  = 1'b1;

        step(1'b1, 4'd5, 4'd5, 1'b1, "reset0");
        step(1'b1, 4'd5, 4'd5, 1'b1, "reset1");

        step(1'b0, 4'd3,  4'd4,  1'b1, "d_3_4_1");
        step(1'b0, 4'd4,  4'd5,  1'b0, "d_4_5_0");
        step(1'b0, 4'd6,  4'd7,  1'b1, "d_6_7_1");
        step(1'b0, 4'd8,  4'd8,  1'b1, "d_8_8_1");
        step(1'b0, 4'd15, 4'd15, 1'b1, "d_max");
        step(1'b0, 4'd0,  4'd0,  1'b0, "d_zero");
        step(1'b0, 4'd15, 4'd0,  1'b1, "d_carry_ripple");

        // random back-to-back stream with one reset edge in the middle
        rst_at = $urandom_range(5, 25);
        for (int i = 0; i < 32; i++) begin
            step(i == rst_at, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), (i == rst_at) ? "rand_rst" : "rand");
        end

        for (int k = 0; k < 512; k++) begin
            logic [8:0] kk;
            kk = 9'(k);
            step(1'b0, kk[8:5], kk[4:1], kk[0], "sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
